// File: rtl/mux_gate_pkg.sv
// Shared op codes and FSM state type for the mux-based gate scheduler.
package mux_gate_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {IDLE, EXEC} state_t;
endpackage

// File: rtl/mux_gate_unit.sv
// Combinational 2-input gate built only from 2:1 muxes; a is the final select.
module mux_gate_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module mux_gate_unit (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);
    logic b_n, hi_lo, hi_val, lo_lo, lo_hi, lo_val;

    assign b_n = ~b;

    // a=1 leg: AND->b, OR->1, XOR/NAND->~b
    mux_gate_mux2 u_hi_lo (.sel(op[0]), .d0(b),     .d1(1'b1),  .y(hi_lo));
    mux_gate_mux2 u_hi    (.sel(op[1]), .d0(hi_lo), .d1(b_n),   .y(hi_val));
    // a=0 leg: AND->0, OR/XOR->b, NAND->1
    mux_gate_mux2 u_lo_lo (.sel(op[0]), .d0(1'b0),  .d1(b),     .y(lo_lo));
    mux_gate_mux2 u_lo_hi (.sel(op[0]), .d0(b),     .d1(1'b1),  .y(lo_hi));
    mux_gate_mux2 u_lo    (.sel(op[1]), .d0(lo_lo), .d1(lo_hi), .y(lo_val));
    mux_gate_mux2 u_out   (.sel(a),     .d0(lo_val), .d1(hi_val), .y(y));
endmodule

// File: rtl/mux_gate_scheduler.sv
// Round-robin arbiter sharing one mux gate unit among NUM_REQ requesters.
module mux_gate_scheduler
    import mux_gate_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   a_in,
    input  logic [NUM_REQ-1:0]   b_in,
    input  logic [2*NUM_REQ-1:0] op_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_y,
    output logic                 busy
);
    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, id_q, win;
    logic              a_q, b_q, found, y;
    logic [1:0]        op_q;
    logic [ID_W:0]     sum;

    // First set req bit at or above ptr, wrapping to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!found && req[sum[ID_W-1:0]]) begin
                found = 1'b1;
                win   = sum[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mux_gate_unit u_unit (.a(a_q), .b(b_q), .op(op_q), .y(y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_y     <= 1'b0;
            ptr       <= '0;
            id_q      <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            op_q      <= 2'b00;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            if (state == IDLE && found) begin
                a_q  <= a_in[win];
                b_q  <= b_in[win];
                op_q <= op_in[{win, 1'b0} +: 2];
                id_q <= win;
                gnt  <= NUM_REQ'(1) << win;
            end else if (state == EXEC) begin
                res_y     <= y;
                res_id    <= id_q;
                res_valid <= 1'b1;
                // Pointer moves only on completion, so fairness follows finished ops.
                ptr       <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign busy = (state == EXEC);
endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Directed-vector bench for mux_gate_scheduler with NUM_REQ=4.
module tb_mux_gate_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, a_in, b_in, gnt;
    logic [7:0] op_in;
    logic       res_valid, res_y, busy;
    logic [1:0] res_id;
    int         errors = 0;
    int         checks = 0;

    mux_gate_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .op_in(op_in), .gnt(gnt), .res_valid(res_valid), .res_id(res_id),
        .res_y(res_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_gnt [5];
    logic       exp_y   [4];

    initial begin
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_y   = '{1'b0, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; op_in = '0;
        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_y", 32'(res_y), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Reset mid-EXEC: grant requester 2, then reset during EXEC
        tick();
        req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100; op_in = 8'h00;
        tick();
        chk("mid_gnt_pre", 32'(gnt), 32'b0100);
        chk("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt), 0);
        chk("mid_valid", 32'(res_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        req = '0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_valid", 32'(res_valid), 0);
        end

        // Contention from reset: all request OR with a=1 -> y=1
        req = 4'b1111; a_in = 4'b1111; b_in = 4'b0000; op_in = 8'b01010101;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_gnt", 32'(gnt), 32'(exp_gnt[i]));
            chk("cont_busy", 32'(busy), 1);
            tick();
            chk("cont_valid", 32'(res_valid), 1);
            chk("cont_id", 32'(res_id), i);
            chk("cont_y", 32'(res_y), 1);
            chk("cont_gnt_off", 32'(gnt), 0);
        end

        // Pointer wrap: id 3 done, now req=1001
        req = 4'b1001;
        tick();
        chk("wrap_gnt0", 32'(gnt), 32'b0001);
        tick();
        chk("wrap_id0", 32'(res_id), 0);
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'b1000);
        tick();
        chk("wrap_id3", 32'(res_id), 3);
        chk("wrap_valid3", 32'(res_valid), 1);

        // Single requester 0, a=1 b=0, all four ops
        req = '0; a_in = 4'b0001; b_in = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            op_in = {6'b0, 2'(i)};
            req = 4'b0001;
            tick();
            chk("op_gnt", 32'(gnt), 32'b0001);
            chk("op_valid_early", 32'(res_valid), 0);
            req = '0;
            tick();
            chk("op_valid", 32'(res_valid), 1);
            chk("op_y", 32'(res_y), 32'(exp_y[i]));
            chk("op_id", 32'(res_id), 0);
        end

        // Operand capture: req1 a=0 b=1 XOR, flip a during gnt
        a_in = 4'b0000; b_in = 4'b0010; op_in = 8'b0000_1000; req = 4'b0010;
        tick();
        chk("cap_gnt", 32'(gnt), 32'b0010);
        a_in = 4'b0010; req = '0;
        tick();
        chk("cap_valid", 32'(res_valid), 1);
        chk("cap_y", 32'(res_y), 1);
        chk("cap_id", 32'(res_id), 1);

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {gnt, res_valid, busy}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
